// File: rtl/pwm_cfg_sequencer_if.sv
// APB write-port bundle between the PWM configuration sequencer (master)
// and the PWM32 register slave.
interface pwm_cfg_sequencer_if;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic        PREADY;

    modport master (
        output PADDR,
        output PWRITE,
        output PSEL,
        output PENABLE,
        output PWDATA,
        input  PREADY
    );

    modport slave (
        input  PADDR,
        input  PWRITE,
        input  PSEL,
        input  PENABLE,
        input  PWDATA,
        output PREADY
    );
endinterface

// File: rtl/pwm_cfg_sequencer.sv
// Replays a programmed table of APB writes into the PWM32 slave, optionally
// holding each entry until the PWM period-boundary strobe so updates land glitch-free.
module pwm_cfg_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     cmd_we,
    input  logic [$clog2(DEPTH)-1:0] cmd_idx,
    input  logic [31:0]              cmd_addr,
    input  logic [31:0]              cmd_data,
    input  logic                     cmd_sync,
    input  logic [$clog2(DEPTH):0]   num_cmds,
    input  logic                     loop,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     sync,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    pwm_cfg_sequencer_if.master      apb
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NUM_W = IDX_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_SETUP     = 2'd2,
        ST_ACCESS    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               loop_q, loop_d;
    logic               stop_q, stop_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [31:0]        paddr_q, paddr_d;
    logic [31:0]        pwdata_q, pwdata_d;

    logic [31:0]        tbl_addr_q [DEPTH];
    logic [31:0]        tbl_addr_d [DEPTH];
    logic [31:0]        tbl_data_q [DEPTH];
    logic [31:0]        tbl_data_d [DEPTH];
    logic               tbl_sync_q [DEPTH];
    logic               tbl_sync_d [DEPTH];

    logic [NUM_W-1:0]   eff_num_s;
    logic               last_s;
    logic               stop_seen_s;
    logic [IDX_W-1:0]   nxt_idx_s;
    logic               tbl_wr_s;

    // Sequencer next-state, entry index, stop latch, wait counter and next output values
    always_comb begin
        eff_num_s   = (num_cmds > NUM_W'(DEPTH)) ? NUM_W'(DEPTH) : num_cmds;
        last_s      = ({1'b0, idx_q} == (eff_num_s - NUM_W'(1)));
        stop_seen_s = stop_q | stop;
        nxt_idx_s   = idx_q + IDX_W'(1);

        state_d = state_q;
        idx_d   = idx_q;
        loop_d  = loop_q;
        stop_d  = stop_seen_s;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (start && (eff_num_s != NUM_W'(0))) begin
                    loop_d  = loop;
                    idx_d   = IDX_W'(0);
                    state_d = tbl_sync_q[0] ? ST_WAIT_SYNC : ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_SYNC: begin
                // A stop abandons the wait at once; sync outside this state is ignored.
                if (stop_seen_s) begin
                    stop_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (sync) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_WAIT_SYNC;
                end
            end
            ST_SETUP: begin
                cnt_d   = CNT_W'(0);
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (apb.PREADY) begin
                    if (stop_seen_s) begin
                        stop_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (last_s) begin
                        if (loop_q) begin
                            idx_d   = IDX_W'(0);
                            state_d = tbl_sync_q[0] ? ST_WAIT_SYNC : ST_SETUP;
                        end else begin
                            done_d  = 1'b1;
                            stop_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d   = nxt_idx_s;
                        state_d = tbl_sync_q[nxt_idx_s] ? ST_WAIT_SYNC : ST_SETUP;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    stop_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                stop_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d = (state_d == ST_ACCESS);
        pwrite_d  = psel_d;
        busy_d    = (state_d != ST_IDLE);
        if (state_d == ST_SETUP) begin
            paddr_d  = tbl_addr_q[idx_d];
            pwdata_d = tbl_data_q[idx_d];
        end else begin
            paddr_d  = paddr_q;
            pwdata_d = pwdata_q;
        end
    end

    // Command table update; software may only rewrite it while the sequencer is idle
    always_comb begin
        tbl_wr_s = cmd_we && (state_q == ST_IDLE);
        for (int i = 0; i < DEPTH; i++) begin
            if (tbl_wr_s && (cmd_idx == IDX_W'(i))) begin
                tbl_addr_d[i] = cmd_addr;
                tbl_data_d[i] = cmd_data;
                tbl_sync_d[i] = cmd_sync;
            end else begin
                tbl_addr_d[i] = tbl_addr_q[i];
                tbl_data_d[i] = tbl_data_q[i];
                tbl_sync_d[i] = tbl_sync_q[i];
            end
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            idx_q     <= IDX_W'(0);
            loop_q    <= 1'b0;
            stop_q    <= 1'b0;
            cnt_q     <= CNT_W'(0);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= 32'h0000_0000;
            pwdata_q  <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            loop_q    <= loop_d;
            stop_q    <= stop_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    // Command table storage, cleared by reset
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tbl_addr_q <= '{default: 32'h0000_0000};
            tbl_data_q <= '{default: 32'h0000_0000};
            tbl_sync_q <= '{default: 1'b0};
        end else begin
            tbl_addr_q <= tbl_addr_d;
            tbl_data_q <= tbl_data_d;
            tbl_sync_q <= tbl_sync_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;

endmodule

// File: doc/pwm_cfg_sequencer.md
Name: pwm_cfg_sequencer

Overview:
APB master that replays a small programmed table of register writes into the PWM32 APB slave (compare/period/control registers). Each entry can be held until a PWM period-boundary strobe, so duty and period updates land glitch-free. A one-shot or looping run starts on `start`. It sits between the SoC control logic and the PWM's APB slave port and is the only master on that port.

Parameters:
DEPTH, 8, number of command-table entries (power of 2, 2..16)
TIMEOUT, 16, max ACCESS cycles with PREADY low before abort (>=2)

Ports:
PCLK  in  1  clock
PRESET  in  1  synchronous active-high reset
cmd_we  in  1  table write strobe; honoured only when busy=0
cmd_idx  in  log2(DEPTH)  table entry index for cmd_we
cmd_addr  in  32  APB address for entry
cmd_data  in  32  APB write data for entry
cmd_sync  in  1  1 = wait for sync pulse before issuing entry
num_cmds  in  log2(DEPTH)+1  entries per run; values >DEPTH clamp to DEPTH
loop  in  1  sampled at start; 1 = restart at entry 0 after last entry
start  in  1  single-cycle run request
stop  in  1  abort request
sync  in  1  PWM period-boundary strobe
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse on PREADY timeout
PADDR  out  32  APB address
PWRITE  out  1  APB direction, always 1 during a transfer
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWDATA  out  32  APB write data
PREADY  in  1  APB ready from slave

Behaviour:
- Reset (PRESET high at a PCLK edge): state IDLE; table cleared to 0; idx=0; all outputs 0. Reset mid-transfer drops PSEL/PENABLE on the next edge.
- States: IDLE, WAIT_SYNC, SETUP, ACCESS.
- IDLE: start=1 with effective num_cmds>0 latches loop, sets idx=0, and moves next cycle to WAIT_SYNC if entry[0].sync, else SETUP. start with num_cmds=0 is ignored. start while busy is ignored.
- WAIT_SYNC: sync is sampled only in this state; pulses outside it are dropped, not latched. sync=1 -> SETUP next cycle. stop=1 -> IDLE next cycle, no done.
- SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA = entry[idx]; always -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1, addr/data held. Wait-cycle counter starts at 0.
  - PREADY=1 completes the transfer.
  - PREADY=0 increments the counter. When the counter reaches TIMEOUT: err pulse, PSEL=PENABLE=0, go IDLE. This is a fault abort.
- Transfer completion, decided in order:
  - stop seen during the transfer -> IDLE, no done.
  - Else if idx is the last entry: if loop, idx=0 and continue; otherwise done=1 for one cycle and go IDLE.
  - Else idx+1, then go to WAIT_SYNC or SETUP per the next entry's sync bit.
- Back-to-back transfers: SETUP immediately follows a completed ACCESS, so PSEL stays high and PENABLE drops for 1 cycle. Minimum 2 cycles per transfer.
- stop is latched from any busy cycle. It never breaks an in-flight APB transfer; it takes effect at the next completion or immediately in WAIT_SYNC. Cleared on return to IDLE.
- done and err are never asserted in the same cycle. busy drops in the cycle done or err is high.
- Table writes while busy=1 are dropped. The table is read live, so num_cmds changes during a run are undefined; software must not do this.

Test Plan:
- Load entries 0:(0x0000_0000,0x0000_0064), 1:(0x0000_0004,0x0000_0032), sync=0, num_cmds=2, start -> two APB writes. PSEL rises 1 cycle after start. PENABLE is high 1 cycle each with PREADY=1. done pulses on the cycle after the 2nd ACCESS. Total busy = 4 cycles.
- Entry 0 sync=1, sync pulse 10 cycles after start -> PSEL stays 0 until the cycle after sync. A sync pulse given before start has no effect.
- PREADY held low 3 cycles in ACCESS -> PENABLE high 4 cycles, PADDR/PWDATA stable throughout, transfer then completes normally.
- PREADY held low forever, TIMEOUT=16 -> err pulses after 16 low ACCESS cycles, PSEL drops, busy=0, done never asserted.
- loop=1, 3 entries: writes repeat 0,1,2,0,1,… Assert stop during entry 1's ACCESS -> entry 1 completes, no further SETUP, no done, busy=0 next cycle.
- Assert PRESET during ACCESS -> PSEL, PENABLE and busy are 0 after the edge. Subsequent start with num_cmds=1 writes 0x0/0x0, since the table was cleared.
